// File: rtl/osif_pkt_tx.sv
// ---------------------------------------------------------------------------
// osif_pkt_tx
// AXI4-Stream master that sends one result/status packet per accepted start:
// a fixed header word, then tx_len payload words pulled from an internal
// producer over a valid/ready port. TLAST marks the final beat. All M_AXIS_*
// outputs come from a single registered output stage that runs at full
// throughput.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   tx_start / tx_len          packet request and payload word count
//   tx_busy / tx_done          packet in flight / one-cycle completion pulse
//   osif_*_din                 producer data, strobes and valid
//   osif_ready_dout            producer word taken this cycle (combinational)
//   M_AXIS_*                   stream master interface
//
// state  | meaning
// IDLE   | waiting for tx_start
// HEAD   | header word waiting for a free output register
// DATA   | moving producer words into the output register
// FLUSH  | last beat loaded, waiting for its handshake
// ---------------------------------------------------------------------------
module osif_pkt_tx #(
    parameter int unsigned           TBITS    = 64,
    parameter int unsigned           TBYTE    = 8,
    parameter int unsigned           LEN_BITS = 16,
    parameter logic [TBITS-1:0]      PKT_HEAD = 64'hefef9876cdcdff33
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tx_start,
    input  logic [LEN_BITS-1:0] tx_len,
    output logic                tx_busy,
    output logic                tx_done,
    input  logic [TBITS-1:0]    osif_data_din,
    input  logic [TBYTE-1:0]    osif_strb_din,
    input  logic                osif_valid_din,
    output logic                osif_ready_dout,
    output logic                M_AXIS_TVALID,
    input  logic                M_AXIS_TREADY,
    output logic [TBITS-1:0]    M_AXIS_TDATA,
    output logic [TBYTE-1:0]    M_AXIS_TKEEP,
    output logic                M_AXIS_TLAST
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HEAD  = 2'd1,
        S_DATA  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    localparam logic [LEN_BITS-1:0] LEN_ONE = LEN_BITS'(1);

    state_t              state_q, state_d;
    logic [LEN_BITS-1:0] len_q, len_d;
    logic [LEN_BITS-1:0] cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                tvalid_q, tvalid_d;
    logic [TBITS-1:0]    tdata_q, tdata_d;
    logic [TBYTE-1:0]    tkeep_q, tkeep_d;
    logic                tlast_q, tlast_d;

    logic load_ok;
    logic beat_fire;
    logic last_word;

    // The output register can take a new word when it is empty or its
    // current beat is leaving this cycle.
    assign load_ok   = !tvalid_q || M_AXIS_TREADY;
    assign beat_fire = tvalid_q && M_AXIS_TREADY;
    // Only meaningful in DATA, where len_q is never zero.
    assign last_word = (cnt_q == (len_q - LEN_ONE));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tlast_q  <= tlast_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        len_d           = len_q;
        cnt_d           = cnt_q;
        busy_d          = busy_q;
        done_d          = 1'b0;
        tvalid_d        = tvalid_q;
        tdata_d         = tdata_q;
        tkeep_d         = tkeep_q;
        tlast_d         = tlast_q;
        osif_ready_dout = 1'b0;

        // A beat that leaves without a replacement empties the register;
        // any load below overrides this.
        if (beat_fire) begin
            tvalid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (tx_start) begin
                    len_d   = tx_len;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_HEAD;
                end
            end
            S_HEAD: begin
                if (load_ok) begin
                    tvalid_d = 1'b1;
                    tdata_d  = PKT_HEAD;
                    tkeep_d  = '1;
                    tlast_d  = (len_q == '0);
                    state_d  = (len_q == '0) ? S_FLUSH : S_DATA;
                end
            end
            S_DATA: begin
                osif_ready_dout = load_ok;
                if (osif_valid_din && load_ok) begin
                    tvalid_d = 1'b1;
                    tdata_d  = osif_data_din;
                    tkeep_d  = osif_strb_din;
                    tlast_d  = last_word;
                    cnt_d    = cnt_q + LEN_ONE;
                    if (last_word) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (beat_fire && tlast_q) begin
                    tlast_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign tx_busy       = busy_q;
    assign tx_done       = done_q;
    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TKEEP  = tkeep_q;
    assign M_AXIS_TLAST  = tlast_q;

endmodule
